muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ITER_CNT = 32;
    localparam int unsigned CNT_W    = 6;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// MUL and DIV share one 64-bit working register and one iteration counter.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned WW = 2 * XLEN;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [WW-1:0]     work;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_q;
    logic              neg_r;
    logic              is_div;

    logic              accept_c;
    logic              a_neg_c;
    logic              b_neg_c;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;
    logic              iter_end_c;
    logic [XLEN:0]     mul_sum_c;
    logic [XLEN:0]     div_rem_c;
    logic              div_ge_c;
    logic [XLEN-1:0]   div_sub_c;
    logic [WW-1:0]     prod_fix_c;
    logic [XLEN-1:0]   quo_fix_c;
    logic [XLEN-1:0]   rem_fix_c;

    // Request decode and operand magnitudes for signed ops
    always_comb begin
        accept_c   = start && (state == IDLE) && !busy;
        a_neg_c    = ((op == OP_MULT) || (op == OP_DIV)) && A[XLEN-1];
        b_neg_c    = ((op == OP_MULT) || (op == OP_DIV)) && B[XLEN-1];
        a_mag_c    = a_neg_c ? (~A + XLEN'(1)) : A;
        b_mag_c    = b_neg_c ? (~B + XLEN'(1)) : B;
        iter_end_c = (cnt == CNT_W'(ITER_CNT));
    end

    // Per-iteration datapath and final sign correction
    always_comb begin
        mul_sum_c  = {1'b0, work[WW-1:XLEN]} + {1'b0, (work[0] ? mag_a : XLEN'(0))};
        div_rem_c  = work[WW-1:XLEN-1];
        div_ge_c   = (div_rem_c >= {1'b0, mag_b});
        div_sub_c  = div_rem_c[XLEN-1:0] - mag_b;
        prod_fix_c = neg_q ? (~work + WW'(1)) : work;
        quo_fix_c  = neg_q ? (~work[XLEN-1:0] + XLEN'(1)) : work[XLEN-1:0];
        rem_fix_c  = neg_r ? (~work[WW-1:XLEN] + XLEN'(1)) : work[WW-1:XLEN];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if ((op == OP_MULT) || (op == OP_MULTU)) begin
                        state_nxt = MUL;
                    end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
                        state_nxt = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (iter_end_c) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latches, shared working register, HI/LO and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            work   <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state != IDLE) && (state_nxt != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        case (op)
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                mag_a  <= a_mag_c;
                                mag_b  <= b_mag_c;
                                neg_q  <= a_neg_c ^ b_neg_c;
                                neg_r  <= a_neg_c;
                                is_div <= op[1];
                                cnt    <= '0;
                                work   <= op[1] ? {XLEN'(0), a_mag_c} : {XLEN'(0), b_mag_c};
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (!iter_end_c) begin
                        work <= {mul_sum_c, work[XLEN-1:1]};
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (!iter_end_c) begin
                        work <= div_ge_c ? {div_sub_c, work[XLEN-2:0], 1'b1}
                                         : {div_rem_c[XLEN-1:0], work[XLEN-2:0], 1'b0};
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    cnt <= '0;
                    if (!is_div) begin
                        hi <= prod_fix_c[WW-1:XLEN];
                        lo <= prod_fix_c[XLEN-1:0];
                    end else if (mag_b == '0) begin
                        // Divide by zero returns the original dividend in HI
                        hi <= neg_r ? (~mag_a + XLEN'(1)) : mag_a;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix_c;
                        lo <= quo_fix_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, mthi/mtlo, reserved ops and mid-op reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one iterative op (inputs driven now, accepted at the next edge) and check timing and result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit scramble);
        int busy_cyc = 0;
        int lat      = 0;
        bit seen     = 1'b0;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_accept_busy"}, 64'(busy), 64'd0);
        check({tag, "_accept_done"}, 64'(done), 64'd0);
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (scramble) begin
                A  = $urandom;
                B  = $urandom;
                op = 3'($urandom);
            end
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end else if (busy) begin
                busy_cyc++;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd33);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        A     = '0;
        B     = '0;
        #22;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        // First start is driven right at release and must be taken on the first rising edge
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mult_m2x3",     OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_op("multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_7xm5",     OP_MULT,  32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0);
        run_op("mult_min_x2",   OP_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_op("multu_min_x2",  OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0);
        run_op("div_m7_2",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_100_m7",    OP_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0);
        run_op("divu_7_0",      OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b0);
        run_op("div_m7_0",      OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
        run_op("div_min_m1",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("multu_scram",   OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1);
        run_op("divu_scram",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b1);

        // mthi leaves lo alone and never raises busy/done
        start = 1'b1;
        op    = OP_MTHI;
        A     = 32'h0000CAFE;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mthi_hi", 64'(hi), 64'h0000CAFE);
        check("mthi_lo", 64'(lo), 64'd14);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);

        // Reserved op is ignored entirely
        start = 1'b1;
        op    = 3'b110;
        A     = 32'h11111111;
        B     = 32'h22222222;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy || done) done_cnt++;
            @(posedge clk);
            #1;
        end
        check("rsvd_activity", 64'(done_cnt), 64'd0);
        check("rsvd_hi", 64'(hi), 64'h0000CAFE);
        check("rsvd_lo", 64'(lo), 64'd14);

        // divu in flight, mthi while busy, then reset mid-operation
        start = 1'b1;
        op    = OP_DIVU;
        A     = 32'd1000;
        B     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_MTHI;
        A     = 32'h0000DEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_mthi_hi", 64'(hi), 64'h0000CAFE);
        check("busy_mthi_busy", 64'(busy), 64'd1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        done_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        op    = OP_MTLO;
        A     = 32'h00001234;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h00001234);
        check("mtlo_hi", 64'(hi), 64'd0);
        check("mtlo_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 40; k++) begin
            if (done || busy) done_cnt++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
